// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined add/subtract/accumulate unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_ACC_ADD = 2'b10,
    OP_ACC_SUB = 2'b11
  } addsub_op_e;

  // One extra bit carries the carry/borrow out of the operand width.
  function automatic int res_width(input int data_width);
    return data_width + 1;
  endfunction

  function automatic logic is_acc_op(input addsub_op_e op);
    return (op == OP_ACC_ADD) || (op == OP_ACC_SUB);
  endfunction

endpackage

// File: rtl/addsub_alu.sv
// Combinational datapath: plain add/sub on zero-extended operands, or
// accumulate against acc (cleared first when clr is set).
module addsub_alu
  import addsub_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int RW         = res_width(DATA_WIDTH)
) (
  input  addsub_op_e            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [RW-1:0]         acc,
  input  logic                  clr,
  output logic [RW-1:0]         result,
  output logic [RW-1:0]         acc_next,
  output logic                  acc_we
);

  logic [RW-1:0] a_ext;
  logic [RW-1:0] b_ext;
  logic [RW-1:0] base;

  always_comb begin
    a_ext  = {1'b0, a};
    b_ext  = {1'b0, b};
    base   = clr ? '0 : acc;
    result = '0;
    unique case (op)
      OP_ADD:     result = a_ext + b_ext;
      OP_SUB:     result = a_ext - b_ext;
      OP_ACC_ADD: result = base + a_ext;
      OP_ACC_SUB: result = base - a_ext;
      default:    result = '0;
    endcase
    acc_we   = is_acc_op(op);
    acc_next = acc_we ? result : base;
  end

endmodule

// File: rtl/addsub_acc_pipe.sv
// Two-stage add/sub/accumulate pipe with valid/ready on both sides.
// Stage 1 holds the captured beat; stage 2 is the output register.
module addsub_acc_pipe
  import addsub_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  localparam int RW         = res_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic                  acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RW-1:0]         data_out,
  output logic [RW-1:0]         acc_out
);

  localparam int STAGES = 2;

  logic [STAGES:1]       vld_pipe_q, vld_pipe_d;
  addsub_op_e            s1_op_q, s1_op_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [DATA_WIDTH-1:0] s1_b_q, s1_b_d;
  logic [RW-1:0]         data_q, data_d;
  logic [RW-1:0]         acc_q, acc_d;

  logic          stall;
  logic          s1_move;
  logic [RW-1:0] alu_result;
  logic [RW-1:0] alu_acc_next;
  logic          alu_acc_we;

  // Whole-pipe stall only when a finished result is refused.
  assign stall    = vld_pipe_q[STAGES] & ~out_ready;
  assign in_ready = ~stall;
  assign s1_move  = vld_pipe_q[1] & ~stall;

  addsub_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op       (s1_op_q),
    .a        (s1_a_q),
    .b        (s1_b_q),
    .acc      (acc_q),
    .clr      (acc_clr),
    .result   (alu_result),
    .acc_next (alu_acc_next),
    .acc_we   (alu_acc_we)
  );

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    data_d     = data_q;
    if (!stall) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
      if (in_valid) begin
        s1_op_d = addsub_op_e'(op);
        s1_a_d  = data_in_1;
        s1_b_d  = data_in_2;
      end
      if (vld_pipe_q[1]) data_d = alu_result;
    end
    // A clear applies even while stalled; a moving ACC beat already saw it.
    acc_d = acc_clr ? '0 : acc_q;
    if (s1_move && alu_acc_we) acc_d = alu_acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_op_q    <= OP_ADD;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      data_q     <= '0;
      acc_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      data_q     <= data_d;
      acc_q      <= acc_d;
    end
  end

  assign out_valid = vld_pipe_q[STAGES];
  assign data_out  = data_q;
  assign acc_out   = acc_q;

endmodule

// File: tb/tb_addsub_acc_pipe.sv
// Scoreboard bench: the driver keeps a beat-level reference model and queues
// expected results; an independent monitor checks whatever the DUT presents.
module tb_addsub_acc_pipe;

  localparam int DW   = 8;
  localparam int MASK = (1 << (DW + 1)) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op = 2'b00;
  logic [DW-1:0] data_in_1 = '0;
  logic [DW-1:0] data_in_2 = '0;
  logic          acc_clr = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW:0]   data_out;
  logic [DW:0]   acc_out;

  addsub_acc_pipe #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .data_in_1 (data_in_1),
    .data_in_2 (data_in_2),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: accumulator, beat waiting to commit, result on offer.
  int q[$];
  int m_acc = 0;
  bit m_ov  = 0;
  bit m_pv  = 0;
  int m_pop = 0;
  int m_pa  = 0;
  int m_pb  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, then advance the model.
  task automatic cyc(input bit iv, input int o, input int a, input int b,
                     input bit ordy, input bit clr, input bit r);
    bit st;
    int base;
    int res;
    @(negedge clk);
    in_valid  = iv;
    op        = o[1:0];
    data_in_1 = a[DW-1:0];
    data_in_2 = b[DW-1:0];
    out_ready = ordy;
    acc_clr   = clr;
    rst       = r;
    #1;
    st = m_ov && !ordy;
    check("in_ready", in_ready, !st);
    @(posedge clk);
    if (r) begin
      m_acc = 0; m_ov = 0; m_pv = 0;
      q.delete();
    end else if (!st) begin
      if (m_pv) begin
        base = clr ? 0 : m_acc;
        case (m_pop)
          0:       res = (m_pa + m_pb) & MASK;
          1:       res = (m_pa - m_pb) & MASK;
          2:       res = (base + m_pa) & MASK;
          default: res = (base - m_pa) & MASK;
        endcase
        m_acc = (m_pop >= 2) ? res : base;
        q.push_back(res);
      end else if (clr) begin
        m_acc = 0;
      end
      m_ov = m_pv;
      m_pv = iv;
      if (iv) begin
        m_pop = o & 3; m_pa = a & 255; m_pb = b & 255;
      end
    end else if (clr) begin
      m_acc = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, 0, 0);
  endtask

  // Monitor: independent of the driver, compares every presented result.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      check("out_valid", out_valid, m_ov);
      check("acc_out", acc_out, m_acc);
      if (out_valid) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_unexpected: got data_out %0h want no result", data_out);
        end else begin
          check("data_out", data_out, q[0]);
          if (out_ready && !rst) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    cyc(0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 1);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_acc_out", acc_out, 0);

    // ADD with carry, two cycles from presentation to output
    cyc(1, 0, 200, 100, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    #2;
    check("add_valid", out_valid, 1);
    check("add_carry", data_out, 9'h12C);

    // SUB with and without borrow
    cyc(1, 1, 5, 7, 1, 0, 0);
    cyc(1, 1, 7, 5, 1, 0, 0);
    #2;
    check("sub_borrow", data_out, 9'h1FE);
    cyc(0, 0, 0, 0, 1, 0, 0);
    #2;
    check("sub_plain", data_out, 2);

    // Back-to-back accumulate chain
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(1, 2, 10, 99, 1, 0, 0);
    cyc(1, 2, 20, 99, 1, 0, 0);
    cyc(1, 3, 5, 99, 1, 0, 0);
    idle(2);
    #2;
    check("acc_chain", acc_out, 25);

    // Accumulate past the operand width
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(1, 2, 255, 0, 1, 0, 0);
    cyc(1, 2, 255, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    #2;
    check("acc_wide", data_out, 9'h1FE);
    check("acc_wide_reg", acc_out, 9'h1FE);

    // Backpressure: out_ready low for 3 cycles mid-stream
    cyc(1, 0, 1, 1, 1, 0, 0);
    cyc(1, 0, 2, 2, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 3, 3, 0, 0, 0);
    cyc(1, 0, 3, 3, 1, 0, 0);
    cyc(1, 0, 4, 4, 1, 0, 0);
    idle(3);

    // Clear coincident with an ACC beat entering stage 2
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(1, 2, 40, 0, 1, 0, 0);
    idle(2);
    #2;
    check("clr_pre_acc", acc_out, 40);
    cyc(1, 2, 7, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    #2;
    check("clr_coinc_data", data_out, 7);
    check("clr_coinc_acc", acc_out, 7);

    // Reset with two beats in flight
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(1, 2, 50, 0, 1, 0, 0);
    idle(2);
    cyc(1, 0, 9, 9, 1, 0, 0);
    cyc(1, 0, 8, 8, 1, 0, 0);
    cyc(1, 0, 6, 6, 1, 0, 1);
    #2;
    check("midrst_valid", out_valid, 0);
    check("midrst_data", data_out, 0);
    check("midrst_acc", acc_out, 0);
    idle(3);
    cyc(1, 0, 3, 4, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    #2;
    check("post_rst_add", data_out, 7);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 4) != 0, $urandom % 4, $urandom % 256, $urandom % 256,
          ($urandom % 4) != 0, ($urandom % 16) == 0, ($urandom % 97) == 0);
    end

    // Bounded drain
    for (int i = 0; i < 10; i++) begin
      if (q.size() != 0 || m_ov) idle(1);
    end
    idle(1);
    check("drain_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
